uart_tx_serializer: RTL and testbench

Serial transmit engine that sits directly downstream of the CPU-side transmit FIFO. It pops bytes from the FIFO and shifts them out on TX as asynchronous serial frames: start bit, data LSB-first, optional parity, then stop bit(s). Bit timing comes from the divisor value held in the baud rate divisor register. Status outputs feed the status and interrupt logic.

---
 rtl/uart_tx_serializer_if.sv | 33 +++
 rtl/uart_tx_serializer.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer_if
//
// Handshake between the transmit serializer and the first-word-fall-through
// TX FIFO that feeds it.
//
//   fifo_empty : FIFO has no data (driven by the FIFO)
//   fifo_data  : head-of-FIFO word, valid whenever fifo_empty is low
//   fifo_pop   : one-cycle pop strobe (driven by the serializer)
//
// Modports:
//   master : serializer side, consumes words and issues pops
//   slave  : FIFO side, presents words and accepts pops
// ---------------------------------------------------------------------------
interface uart_tx_serializer_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_pop;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_pop
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_pop
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Pops words from the TX FIFO and shifts them out as asynchronous serial
// frames: start bit, DATA_W data bits LSB first, optional parity bit, then
// STOP_BITS stop periods. One bit period is divisor+1 clock cycles, with the
// divisor captured when the word is popped and held for the whole frame.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   enable_i   : transmit enable, gates the start of new frames only
//   divisor_i  : baud divisor, bit period = divisor_i+1 cycles
//   fifo       : FIFO handshake (empty / data in, pop out)
//   tx_o       : registered serial output, idle high
//   busy_o     : frame in progress
//   tx_done_o  : one-cycle pulse on the last cycle of the final stop bit
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic [7:0]            divisor_i,
    uart_tx_serializer_if.master  fifo,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  tx_done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [2:0] LAST_DATA = 3'(DATA_W - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic       ODD_SENSE = (PARITY_ODD != 0);

    state_t            state_q;
    logic [7:0]        baud_q;
    logic [7:0]        div_q;
    logic [2:0]        bit_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic              parity_q;
    logic              tx_q;
    logic              busy_q;

    logic              baud_end;
    logic              last_stop;
    logic              pop_w;

    assign baud_end  = (baud_q == div_q);
    assign last_stop = (state_q == S_STOP) && baud_end && (bit_q == LAST_STOP);
    assign shift_d   = shift_q >> 1;

    // A new word may be taken when idle or in the very last cycle of a frame,
    // which is what makes consecutive frames run back-to-back. The pop is
    // gated by rst so that a FIFO with data cannot be drained while held in
    // reset.
    assign pop_w = !rst && enable_i && !fifo.fifo_empty &&
                   ((state_q == S_IDLE) || last_stop);

    assign fifo.fifo_pop = pop_w;
    assign tx_o          = tx_q;
    assign busy_o        = busy_q;
    assign tx_done_o     = last_stop;

    // Frame sequencer. tx_q is loaded with the level of the state/bit being
    // entered, so the line changes one cycle after each transition decision.
    // Parity is taken from the whole word at load time because the shift
    // register is consumed as the data bits go out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            div_q    <= '0;
            parity_q <= 1'b0;
        end else if (pop_w) begin
            state_q  <= S_START;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= fifo.fifo_data;
            div_q    <= divisor_i;
            parity_q <= (^fifo.fifo_data) ^ ODD_SENSE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end

                S_START: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 8'd1;
                    end
                end

                S_DATA: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        shift_q <= shift_d;
                        if (bit_q == LAST_DATA) begin
                            bit_q <= '0;
                            if (PARITY_EN != 0) begin
                                state_q <= S_PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shift_d[0];
                        end
                    end else begin
                        baud_q <= baud_q + 8'd1;
                    end
                end

                S_PARITY: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 8'd1;
                    end
                end

                S_STOP: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == LAST_STOP) begin
                            bit_q   <= '0;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 8'd1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Bench for uart_tx_serializer. Instance A (8N1) is fed from a queue-based
// FIFO and shadowed every cycle by a frame-level reference model that turns
// each popped word into its expected per-cycle line levels. Instances B
// (8 bits, even parity) and C (7 bits, odd parity, 2 stop bits) cover the
// parity and multi-stop variants.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enableR = 1'b0;
    logic [7:0] divisorR = 8'd0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A and its FIFO
    logic [7:0] fifoQ[$];
    logic       txA, busyA, doneA;

    uart_tx_serializer_if #(.DATA_W(8)) ifA ();
    assign ifA.fifo_empty = (fifoQ.size() == 0);
    assign ifA.fifo_data  = (fifoQ.size() != 0) ? fifoQ[0] : 8'h00;

    uart_tx_serializer #(
        .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dutA (
        .clk(clk), .rst(rst), .enable_i(enableR), .divisor_i(divisorR),
        .fifo(ifA), .tx_o(txA), .busy_o(busyA), .tx_done_o(doneA)
    );

    // Instances B and C share a single-word source
    logic       emptyP = 1'b1;
    logic [7:0] dataP = 8'h00;
    logic       txB, busyB, doneB;
    logic       txC, busyC, doneC;

    uart_tx_serializer_if #(.DATA_W(8)) ifB ();
    uart_tx_serializer_if #(.DATA_W(7)) ifC ();
    assign ifB.fifo_empty = emptyP;
    assign ifB.fifo_data  = dataP;
    assign ifC.fifo_empty = emptyP;
    assign ifC.fifo_data  = dataP[6:0];

    uart_tx_serializer #(
        .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dutB (
        .clk(clk), .rst(rst), .enable_i(enableR), .divisor_i(divisorR),
        .fifo(ifB), .tx_o(txB), .busy_o(busyB), .tx_done_o(doneB)
    );

    uart_tx_serializer #(
        .DATA_W(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
    ) dutC (
        .clk(clk), .rst(rst), .enable_i(enableR), .divisor_i(divisorR),
        .fifo(ifC), .tx_o(txC), .busy_o(busyC), .tx_done_o(doneC)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: expected line level per cycle for frames in flight,
    // plus a flag marking the final cycle of each frame
    bit expTx[$];
    bit expLast[$];

    function automatic void appendFrame(input logic [7:0] data, input int div);
        bit lvl;
        for (int p = 0; p < 10; p++) begin
            if (p == 0)      lvl = 1'b0;
            else if (p == 9) lvl = 1'b1;
            else             lvl = data[p-1];
            for (int r = 0; r <= div; r++) begin
                expTx.push_back(lvl);
                expLast.push_back((p == 9) && (r == div));
            end
        end
    endfunction

    // Per-cycle scoreboard for instance A, sampled mid-cycle. The FIFO head
    // is retired just after the edge that consumed it.
    initial begin : scoreboard
        bit   hadFrame;
        bit   expPop;
        bit   expDone;
        bit   expLvl;
        logic popPending;
        forever begin
            @(negedge clk);
            if (rst) begin
                expTx.delete();
                expLast.delete();
            end
            hadFrame = (expTx.size() != 0);
            expLvl   = hadFrame ? expTx[0] : 1'b1;
            expDone  = hadFrame && expLast[0];
            expPop   = !rst && enableR && (fifoQ.size() != 0) && (!hadFrame || expDone);
            checkOutput("sb_tx",   txA,          expLvl);
            checkOutput("sb_busy", busyA,        hadFrame);
            checkOutput("sb_done", doneA,        expDone);
            checkOutput("sb_pop",  ifA.fifo_pop, expPop);
            if (hadFrame) begin
                void'(expTx.pop_front());
                void'(expLast.pop_front());
            end
            if (expPop) appendFrame(fifoQ[0], int'(divisorR));
            popPending = ifA.fifo_pop;
            @(posedge clk);
            #1;
            if (popPending === 1'b1 && fifoQ.size() != 0) void'(fifoQ.pop_front());
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic pushByte(input logic [7:0] b);
        fifoQ.push_back(b);
    endtask

    task automatic waitPop(input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ifA.fifo_pop === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("pop_seen", seen, 1);
    endtask

    // Receives one 8N1 frame from A starting the cycle after its pop,
    // sampling each bit on the last cycle of its period
    task automatic rxFrame(input int div, output logic [7:0] rxByte,
                           output logic startBit, output logic stopBit,
                           output int doneAt, output int popAt, output bit busyLow);
        int per;
        int p;
        per = div + 1;
        rxByte = '0; startBit = 1'b1; stopBit = 1'b0;
        doneAt = -1; popAt = -1; busyLow = 1'b0;
        for (int c = 1; c <= 10 * per; c++) begin
            @(negedge clk);
            if (busyA !== 1'b1) busyLow = 1'b1;
            if (doneA === 1'b1 && doneAt < 0) doneAt = c;
            if (ifA.fifo_pop === 1'b1 && popAt < 0) popAt = c;
            if (c % per == 0) begin
                p = c / per - 1;
                if (p == 0)      startBit = txA;
                else if (p == 9) stopBit = txA;
                else             rxByte[p-1] = txA;
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] div;
        logic [7:0] expByte;
        int         expDone;
    } vec_t;

    task automatic applyStimulus(input vec_t v);
        logic [7:0] b;
        logic       s, t;
        int         d, p;
        bit         bl;
        nextCycle();
        divisorR = v.div;
        pushByte(v.data);
        waitPop(20);
        rxFrame(int'(v.div), b, s, t, d, p, bl);
        checkOutput("vec_start", s, 0);
        checkOutput("vec_byte",  b, v.expByte);
        checkOutput("vec_stop",  t, 1);
        checkOutput("vec_done",  d, v.expDone);
        checkOutput("vec_nopop", p, -1);
        @(negedge clk);
        checkOutput("vec_idle_busy", busyA, 0);
        checkOutput("vec_idle_tx",   txA,   1);
    endtask

    // Runs one word through B and C together with divisor 1 (2-cycle bits)
    task automatic parityFrame(input logic [7:0] data);
        logic bitsB[11];
        logic bitsC[11];
        int   doneB_at, doneC_at, ones8, ones7, p;
        bit   seen;
        logic [7:0] rxB;
        logic [6:0] rxC;
        nextCycle();
        divisorR = 8'd1;
        dataP    = data;
        emptyP   = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifB.fifo_pop === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("par_popB", seen, 1);
        checkOutput("par_popC", ifC.fifo_pop, 1);
        @(posedge clk);
        #2;
        emptyP = 1'b1;
        doneB_at = -1;
        doneC_at = -1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (doneB === 1'b1 && doneB_at < 0) doneB_at = c;
            if (doneC === 1'b1 && doneC_at < 0) doneC_at = c;
            if (c % 2 == 0) begin
                p = c / 2 - 1;
                bitsB[p] = txB;
                bitsC[p] = txC;
            end
        end
        ones8 = 0;
        ones7 = 0;
        for (int i = 0; i < 8; i++) if (data[i]) ones8++;
        for (int i = 0; i < 7; i++) if (data[i]) ones7++;
        for (int i = 0; i < 8; i++) rxB[i] = bitsB[i+1];
        for (int i = 0; i < 7; i++) rxC[i] = bitsC[i+1];
        checkOutput("parB_start",  bitsB[0], 0);
        checkOutput("parB_data",   rxB, data);
        checkOutput("parB_parity", bitsB[9], (ones8 % 2 == 1) ? 1 : 0);
        checkOutput("parB_stop",   bitsB[10], 1);
        checkOutput("parB_done",   doneB_at, 22);
        checkOutput("parC_start",  bitsC[0], 0);
        checkOutput("parC_data",   rxC, data[6:0]);
        checkOutput("parC_parity", bitsC[8], (ones7 % 2 == 1) ? 0 : 1);
        checkOutput("parC_stop1",  bitsC[9], 1);
        checkOutput("parC_stop2",  bitsC[10], 1);
        checkOutput("parC_done",   doneC_at, 22);
    endtask

    // Main sequence
    initial begin : stimulus
        vec_t       vecs[4];
        logic [7:0] b;
        logic       s, t;
        int         d, p, pops;
        bit         bl, txBad;

        vecs[0] = '{data: 8'hA5, div: 8'd3, expByte: 8'hA5, expDone: 40};
        vecs[1] = '{data: 8'h3C, div: 8'd0, expByte: 8'h3C, expDone: 10};
        vecs[2] = '{data: 8'h81, div: 8'd1, expByte: 8'h81, expDone: 20};
        vecs[3] = '{data: 8'h5A, div: 8'd5, expByte: 8'h5A, expDone: 60};

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_tx",    txA,   1);
        checkOutput("rst_busy",  busyA, 0);
        checkOutput("rst_done",  doneA, 0);
        checkOutput("rst_pop",   ifA.fifo_pop, 0);
        checkOutput("rst_txB",   txB,   1);
        checkOutput("rst_busyC", busyC, 0);
        nextCycle();
        rst     = 1'b0;
        enableR = 1'b1;

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

        // Back-to-back frames at one cycle per bit
        nextCycle();
        divisorR = 8'd0;
        pushByte(8'h00);
        pushByte(8'hFF);
        waitPop(20);
        rxFrame(0, b, s, t, d, p, bl);
        checkOutput("b2b_byte1", b, 8'h00);
        checkOutput("b2b_done1", d, 10);
        checkOutput("b2b_pop2",  p, 10);
        checkOutput("b2b_busy1", bl, 0);
        rxFrame(0, b, s, t, d, p, bl);
        checkOutput("b2b_start2", s, 0);
        checkOutput("b2b_byte2",  b, 8'hFF);
        checkOutput("b2b_done2",  d, 10);
        checkOutput("b2b_busy2",  bl, 0);
        @(negedge clk);
        checkOutput("b2b_idle", busyA, 0);

        // Divisor changed mid-frame only affects the following frame
        nextCycle();
        divisorR = 8'd3;
        pushByte(8'h3C);
        waitPop(20);
        fork
            begin
                repeat (12) @(posedge clk);
                #2;
                divisorR = 8'd7;
                pushByte(8'hC3);
            end
        join_none
        rxFrame(3, b, s, t, d, p, bl);
        checkOutput("div_byte1", b, 8'h3C);
        checkOutput("div_done1", d, 40);
        checkOutput("div_pop2",  p, 40);
        rxFrame(7, b, s, t, d, p, bl);
        checkOutput("div_byte2", b, 8'hC3);
        checkOutput("div_done2", d, 80);

        // Disabled with data waiting: nothing leaves the FIFO
        nextCycle();
        enableR  = 1'b0;
        divisorR = 8'd1;
        pushByte(8'h42);
        pops  = 0;
        txBad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ifA.fifo_pop === 1'b1) pops++;
            if (txA !== 1'b1) txBad = 1'b1;
        end
        checkOutput("dis_pops", pops, 0);
        checkOutput("dis_tx",   txBad, 0);

        // Enable dropped mid-frame: frame completes, no further pop
        nextCycle();
        enableR = 1'b1;
        waitPop(5);
        fork
            begin
                repeat (6) @(posedge clk);
                #2;
                enableR = 1'b0;
                pushByte(8'h99);
            end
        join_none
        rxFrame(1, b, s, t, d, p, bl);
        checkOutput("drop_byte",  b, 8'h42);
        checkOutput("drop_done",  d, 20);
        checkOutput("drop_nopop", p, -1);
        pops = 0;
        repeat (30) begin
            @(negedge clk);
            if (ifA.fifo_pop === 1'b1) pops++;
        end
        checkOutput("drop_pops", pops, 0);
        nextCycle();
        enableR = 1'b1;
        waitPop(5);
        rxFrame(1, b, s, t, d, p, bl);
        checkOutput("drop_resume", b, 8'h99);

        // Reset during data bit 4 abandons the frame and loses that word
        nextCycle();
        divisorR = 8'd3;
        pushByte(8'hE7);
        pushByte(8'h18);
        waitPop(20);
        repeat (22) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_tx",   txA,   1);
        checkOutput("mid_rst_busy", busyA, 0);
        checkOutput("mid_rst_pop",  ifA.fifo_pop, 0);
        checkOutput("mid_rst_done", doneA, 0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        waitPop(5);
        rxFrame(3, b, s, t, d, p, bl);
        checkOutput("mid_rst_next", b, 8'h18);

        // Parity variants
        parityFrame(8'h07);
        parityFrame(8'h80);
        parityFrame(8'h5B);

        // Randomized traffic, checked by the scoreboard
        nextCycle();
        enableR = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            nextCycle();
            if ($urandom_range(0, 9) == 0 && fifoQ.size() < 4) pushByte(8'($urandom));
            if ($urandom_range(0, 59) == 0) enableR = ~enableR;
            if ($urandom_range(0, 29) == 0) divisorR = 8'($urandom_range(0, 3));
        end
        enableR = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            nextCycle();
            if (fifoQ.size() == 0 && busyA === 1'b0) break;
        end
        checkOutput("rand_drained", fifoQ.size(), 0);
        checkOutput("rand_idle",    busyA, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
